// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encodings and default width.
package seq_restoring_divider_pkg;

  localparam int W_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor when it fits.
module div_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] r_in,
  input  logic         n_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] r_out,
  output logic         q_bit
);

  logic [W:0] shifted;

  // The remainder stays below the divisor, so W bits hold it after each step;
  // with divisor 0 the shifted value simply loses its top bit on the next shift.
  always_comb begin
    shifted = {r_in, n_bit};
    if (shifted >= {1'b0, divisor}) begin
      r_out = W'(shifted - {1'b0, divisor});
      q_bit = 1'b1;
    end else begin
      r_out = shifted[W-1:0];
      q_bit = 1'b0;
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional DIV_BY_ZERO_EN adds the dbz port and a single-cycle divide-by-zero shortcut.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] quotient,
  output logic [W-1:0]   remainder
`ifdef DIV_BY_ZERO_EN
  ,
  output logic           dbz
`endif
);

  localparam int CW = $clog2(2*W);
  localparam logic [CW-1:0] COUNT_TOP = CW'(2*W-1);

  state_t         state, state_next;
  logic [2*W-1:0] n_q;
  logic [W-1:0]   d_q;
  logic [W-1:0]   r_q;
  logic [CW-1:0]  count_q;
  logic [W-1:0]   r_step;
  logic           q_bit;
  logic           accept;
  logic           zero_skip;

`ifdef DIV_BY_ZERO_EN
  assign zero_skip = (divisor == '0);
`else
  assign zero_skip = 1'b0;
`endif

  div_step #(.W(W)) u_step (
    .r_in    (r_q),
    .n_bit   (n_q[count_q]),
    .divisor (d_q),
    .r_out   (r_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = zero_skip ? S_DONE : S_CALC;
        end
      end
      S_CALC: if (count_q == '0) state_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep register updates independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      count_q  <= '0;
      quotient <= '0;
`ifdef DIV_BY_ZERO_EN
      dbz      <= 1'b0;
`endif
    end else if (accept) begin
      n_q      <= dividend;
      d_q      <= divisor;
      r_q      <= '0;
      count_q  <= COUNT_TOP;
      quotient <= zero_skip ? '1 : '0;
`ifdef DIV_BY_ZERO_EN
      dbz      <= zero_skip;
`endif
    end else if (state == S_CALC) begin
      r_q               <= r_step;
      quotient[count_q] <= q_bit;
      count_q           <= count_q - 1'b1;
    end
  end

  assign remainder = r_q;

endmodule
